uart_tx_fifo_drain: RTL and testbench
=====================================

Name: uart_tx_fifo_drain

Overview:
Serial UART transmitter that sits directly downstream of the team's synchronous FIFO and drains it byte by byte. It issues one-cycle read requests on the FIFO read interface and accepts the returned word one cycle later. It then serialises that word onto a single TX line as start, data (LSB first), optional parity and stop bits. Baud timing comes from an internal clock-divider counter; no external baud tick is needed.

Parameters:
DATA_WIDTH, 8, width of each FIFO word and number of data bits per frame (>=1)
CLKS_PER_BIT, 16, clk cycles per serial bit (>=2)
PARITY_EN, 0, 1 = append one parity bit after the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)
STOP_BITS, 1, number of stop bits, 1 or 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
tx_en  input  1  level; when high, block may start new frames
fifo_empty  input  1  FIFO empty flag
fifo_read_ready  output  1  read request to FIFO, one-cycle pulse
fifo_read_valid  input  1  FIFO returned data valid (cycle after request)
fifo_data_out  input  DATA_WIDTH  FIFO read data, sampled only when fifo_read_valid=1
tx  output  1  serial line, idle high (mark)
busy  output  1  high from request cycle until end of last stop bit
frame_done  output  1  one-cycle pulse on final cycle of last stop bit
underrun  output  1  sticky; set if fifo_read_valid missing in LOAD, cleared by reset only

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately even mid-frame): state=IDLE, tx=1, busy=0, frame_done=0, fifo_read_ready=0, underrun=0, bit/baud counters=0, shift register=0. An in-flight frame is abandoned; the consumed FIFO word is lost.
- States: IDLE, LOAD, START, DATA, PARITY, STOP.
- IDLE:
  - fifo_read_ready = tx_en && !fifo_empty. It is combinational from state and inputs and is asserted only in IDLE.
  - If asserted, next state = LOAD and busy goes high in that same cycle (combinational). Otherwise remain in IDLE.
  - tx=1.
- LOAD (exactly 1 cycle):
  - If fifo_read_valid=1: capture fifo_data_out into the shift register, compute parity = XOR(data) ^ PARITY_ODD, go to START.
  - If fifo_read_valid=0: set underrun, return to IDLE, no frame sent.
  - tx=1 and fifo_read_ready=0.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - tx = shift[0], LSB first. Shift right after each CLKS_PER_BIT cycles.
  - After DATA_WIDTH bits, go to PARITY if PARITY_EN, else go to STOP.
- PARITY: tx = parity bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - frame_done=1 on the last of these cycles; busy drops at the next edge; go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 and resets on every bit boundary and on state entry. Its width is $clog2(CLKS_PER_BIT). The bit counter width is $clog2(DATA_WIDTH+1).
- Frame length is CLKS_PER_BIT*(1+DATA_WIDTH+PARITY_EN+STOP_BITS) cycles, measured from the first START cycle.
- Back-to-back: with the FIFO non-empty and tx_en=1, the inter-frame mark gap is exactly 2 cycles (IDLE + LOAD) between the last stop cycle and the next start bit.
- tx_en deasserted mid-frame: the current frame completes normally, then the block holds in IDLE with no request.
- fifo_empty is ignored outside IDLE. At most one FIFO word is in flight, so the FIFO's 1-cycle read latency is always met.
- tx is registered (glitch-free). It changes only on clk edges or on reset.
- Elaboration check:
  - $fatal if CLKS_PER_BIT<2, STOP_BITS not in {1,2}, or DATA_WIDTH==0.
  - The check is guarded by `ifndef synthesis.

Test Plan:
1. Reset, CLKS_PER_BIT=4, PARITY_EN=0, FIFO holds 0xA5, tx_en=1 -> single read_ready pulse. tx holds each bit for 4 cycles: 0,1,0,1,0,0,1,0,1,1. frame_done pulses at cycle 40 of the frame; busy=0 afterwards.
2. FIFO holds 0x01,0x80,0xFF, tx_en=1 -> three frames in order. Exactly 2 idle-high cycles between frames. Three read_ready pulses; FIFO ends empty.
3. PARITY_EN=1: send 0xA5 with PARITY_ODD=0 -> parity bit 0. PARITY_ODD=1 -> parity bit 1. 0x07 even -> 1. STOP_BITS=2 -> 8 stop cycles at CLKS_PER_BIT=4.
4. Drop tx_en during DATA bit 3 of a frame with 2 words queued -> current frame completes. No further read_ready; second word stays in the FIFO until tx_en=1.
5. Assert rst_n=0 mid DATA bit 5 -> tx=1 immediately (before the next clk edge), busy=0, state IDLE. After release with FIFO non-empty, a new frame starts cleanly.
6. Force fifo_read_valid=0 in LOAD -> underrun=1 (sticky), tx stays 1, no frame_done. Block returns to IDLE and resumes on the next non-empty FIFO.

Source files
------------

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that drains a synchronous FIFO: one-cycle read request, data one cycle later,
// then start / LSB-first data / optional parity / stop bits, timed by an internal baud divider.
module uart_tx_fifo_drain #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_en,
    input  logic                  fifo_empty,
    output logic                  fifo_read_ready,
    input  logic                  fifo_read_valid,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  underrun
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W  = $clog2(DATA_WIDTH + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic              ODD_SEL   = (PARITY_ODD != 0);

`ifndef synthesis
    if (CLKS_PER_BIT < 2 || DATA_WIDTH == 0 || (STOP_BITS != 1 && STOP_BITS != 2))
    begin : g_param_check
        $fatal(1, "uart_tx_fifo_drain: illegal parameter combination");
    end
`endif

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e                  state;
    logic [BAUD_W-1:0]       baud_cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic [DATA_WIDTH-1:0]   shift;
    logic [DATA_WIDTH-1:0]   shift_nxt;
    logic                    parity_bit;
    logic                    baud_end;

    assign baud_end  = (baud_cnt == BAUD_LAST);
    assign shift_nxt = shift >> 1;

    // Request is gated by rst_n so nothing is asked of the FIFO while reset is held.
    assign fifo_read_ready = rst_n && (state == StIdle) && tx_en && !fifo_empty;
    assign busy            = (state != StIdle) || fifo_read_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            parity_bit <= 1'b0;
            tx         <= 1'b1;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            // Registered pulse: raised on the edge that enters the final stop cycle.
            frame_done <= (state == StStop) && (baud_cnt == BAUD_PRE) && (bit_cnt == STOP_LAST);

            unique case (state)
                StIdle: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (fifo_read_ready) begin
                        state <= StLoad;
                    end
                end

                StLoad: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (fifo_read_valid) begin
                        shift      <= fifo_data_out;
                        parity_bit <= (^fifo_data_out) ^ ODD_SEL;
                        tx         <= 1'b0;
                        state      <= StStart;
                    end else begin
                        underrun <= 1'b1;
                        tx       <= 1'b1;
                        state    <= StIdle;
                    end
                end

                StStart: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= shift[0];
                        state    <= StData;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                StData: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            if (PARITY_EN != 0) begin
                                tx    <= parity_bit;
                                state <= StParity;
                            end else begin
                                tx    <= 1'b1;
                                state <= StStop;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shift   <= shift_nxt;
                            tx      <= shift_nxt[0];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                StParity: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= 1'b1;
                        state    <= StStop;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                StStop: begin
                    tx <= 1'b1;
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            state   <= StIdle;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    tx    <= 1'b1;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: three configurations, each fed by a behavioural FIFO, with every
// frame compared cycle by cycle against a bit list built from the framing rules.
module tb_uart_tx_fifo_drain;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] ten = 3'b000;
    logic [2:0] fe;
    logic [2:0] rdy;
    logic [2:0] vld = 3'b000;
    logic [2:0] txl;
    logic [2:0] bsy;
    logic [2:0] fd;
    logic [2:0] ur;
    logic [2:0] suppress = 3'b000;
    logic [7:0] dout [3];

    logic [7:0] mem [3][64];
    int         wp [3] = '{0, 0, 0};
    int         rp [3] = '{0, 0, 0};
    int         rdy_cnt [3] = '{0, 0, 0};

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // dut0: no parity, 1 stop; dut1: even parity, 2 stop; dut2: odd parity, 1 stop
    uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(C), .PARITY_EN(0), .PARITY_ODD(0),
                         .STOP_BITS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .tx_en(ten[0]), .fifo_empty(fe[0]),
        .fifo_read_ready(rdy[0]), .fifo_read_valid(vld[0]), .fifo_data_out(dout[0]),
        .tx(txl[0]), .busy(bsy[0]), .frame_done(fd[0]), .underrun(ur[0])
    );

    uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(0),
                         .STOP_BITS(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .tx_en(ten[1]), .fifo_empty(fe[1]),
        .fifo_read_ready(rdy[1]), .fifo_read_valid(vld[1]), .fifo_data_out(dout[1]),
        .tx(txl[1]), .busy(bsy[1]), .frame_done(fd[1]), .underrun(ur[1])
    );

    uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(1),
                         .STOP_BITS(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .tx_en(ten[2]), .fifo_empty(fe[2]),
        .fifo_read_ready(rdy[2]), .fifo_read_valid(vld[2]), .fifo_data_out(dout[2]),
        .tx(txl[2]), .busy(bsy[2]), .frame_done(fd[2]), .underrun(ur[2])
    );

    for (genvar g = 0; g < 3; g++) begin : g_fe
        assign fe[g] = (wp[g] == rp[g]);
    end

    // FIFO model: a request pops one word, returned with valid on the following cycle.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rdy[i]) begin
                dout[i]    <= mem[i][rp[i] % 64];
                rp[i]      <= rp[i] + 1;
                vld[i]     <= !suppress[i];
                rdy_cnt[i] <= rdy_cnt[i] + 1;
            end else begin
                vld[i] <= 1'b0;
            end
        end
    end

    function automatic int cfg_par(input int i);
        return (i == 0) ? 0 : 1;
    endfunction

    function automatic int cfg_odd(input int i);
        return (i == 2) ? 1 : 0;
    endfunction

    function automatic int cfg_stop(input int i);
        return (i == 1) ? 2 : 1;
    endfunction

    task automatic push(input int i, input logic [7:0] d);
        mem[i][wp[i] % 64] = d;
        wp[i] = wp[i] + 1;
    endtask

    // Waits for the next start bit (counting mark cycles before it), then checks the whole frame.
    task automatic check_frame(input int i, input logic [7:0] d, input int drop_at,
                               output int gap);
        bit bits[$];
        int len;
        bit found;
        bit want_fd;
        bits.push_back(1'b0);
        for (int b = 0; b < 8; b++) bits.push_back(d[b]);
        if (cfg_par(i) != 0) bits.push_back((($countones(d) % 2) != 0) != (cfg_odd(i) != 0));
        for (int s = 0; s < cfg_stop(i); s++) bits.push_back(1'b1);
        len = bits.size() * C;
        gap = 0;
        found = 1'b0;
        for (int w = 0; w < 300; w++) begin
            @(negedge clk);
            if (txl[i] == 1'b0) begin
                found = 1'b1;
                break;
            end
            gap++;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL start_timeout dut%0d data=%02h: no start bit within 300 cycles", i, d);
            return;
        end
        for (int k = 0; k < len; k++) begin
            if (k > 0) @(negedge clk);
            if (k == drop_at) ten[i] = 1'b0;
            want_fd = (k == len - 1);
            total++;
            if (txl[i] !== bits[k / C]) begin
                bad++;
                $display("FAIL tx_bit dut%0d data=%02h cycle=%0d: got %b want %b",
                         i, d, k, txl[i], bits[k / C]);
            end
            total++;
            if (fd[i] !== want_fd) begin
                bad++;
                $display("FAIL frame_done dut%0d data=%02h cycle=%0d: got %b want %b",
                         i, d, k, fd[i], want_fd);
            end
            total++;
            if (bsy[i] !== 1'b1) begin
                bad++;
                $display("FAIL busy_in_frame dut%0d cycle=%0d: got %b want 1", i, k, bsy[i]);
            end
        end
    endtask

    task automatic test_reset();
        int g;
        rst_n = 1'b0;
        ten = 3'b111;
        push(0, 8'hA5);
        repeat (3) @(negedge clk);
        total++;
        if (txl !== 3'b111) begin
            bad++;
            $display("FAIL reset_tx: got %b want 111", txl);
        end
        total++;
        if (bsy !== 3'b000 || fd !== 3'b000 || ur !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags: got busy=%b done=%b under=%b want 000", bsy, fd, ur);
        end
        total++;
        if (rdy !== 3'b000) begin
            bad++;
            $display("FAIL reset_ready: got %b want 000 (FIFO non-empty, reset held)", rdy);
        end
    endtask

    task automatic test_single();
        int g;
        int r0;
        r0 = rdy_cnt[0];
        rst_n = 1'b1;
        check_frame(0, 8'hA5, -1, g);
        @(negedge clk);
        total++;
        if (rdy_cnt[0] - r0 != 1) begin
            bad++;
            $display("FAIL single_ready_pulses: got %0d want 1", rdy_cnt[0] - r0);
        end
        total++;
        if (bsy[0] !== 1'b0 || txl[0] !== 1'b1) begin
            bad++;
            $display("FAIL single_after: got busy=%b tx=%b want busy=0 tx=1", bsy[0], txl[0]);
        end
    endtask

    task automatic test_back_to_back();
        int g;
        int r0;
        logic [7:0] seq [3];
        seq = '{8'h01, 8'h80, 8'hFF};
        r0 = rdy_cnt[0];
        for (int n = 0; n < 3; n++) push(0, seq[n]);
        for (int n = 0; n < 3; n++) begin
            check_frame(0, seq[n], -1, g);
            if (n > 0) begin
                total++;
                if (g != 2) begin
                    bad++;
                    $display("FAIL b2b_gap frame=%0d: got %0d want 2", n, g);
                end
            end
        end
        repeat (3) @(negedge clk);
        total++;
        if (rdy_cnt[0] - r0 != 3 || fe[0] !== 1'b1) begin
            bad++;
            $display("FAIL b2b_drain: got pulses=%0d empty=%b want pulses=3 empty=1",
                     rdy_cnt[0] - r0, fe[0]);
        end
    endtask

    task automatic test_parity();
        int g;
        push(1, 8'hA5);
        push(1, 8'h07);
        check_frame(1, 8'hA5, -1, g);
        check_frame(1, 8'h07, -1, g);
        total++;
        if (g != 2) begin
            bad++;
            $display("FAIL parity_gap: got %0d want 2", g);
        end
        push(2, 8'hA5);
        check_frame(2, 8'hA5, -1, g);
    endtask

    task automatic test_tx_en_drop();
        int g;
        int r0;
        ten[0] = 1'b1;
        push(0, 8'h3C);
        push(0, 8'hC3);
        check_frame(0, 8'h3C, C * 4 + 1, g);
        r0 = rdy_cnt[0];
        repeat (30) @(negedge clk);
        total++;
        if (rdy_cnt[0] != r0 || bsy[0] !== 1'b0) begin
            bad++;
            $display("FAIL drop_hold: got pulses=%0d busy=%b want 0 0", rdy_cnt[0] - r0, bsy[0]);
        end
        total++;
        if (wp[0] - rp[0] != 1) begin
            bad++;
            $display("FAIL drop_fifo_level: got %0d want 1", wp[0] - rp[0]);
        end
        ten[0] = 1'b1;
        check_frame(0, 8'hC3, -1, g);
    endtask

    task automatic test_reset_mid();
        int g;
        bit found;
        push(0, 8'h5A);
        found = 1'b0;
        for (int w = 0; w < 100; w++) begin
            @(negedge clk);
            if (txl[0] == 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL midreset_start: got no start bit, want one");
        end
        repeat (C * 6 + 1) @(negedge clk);
        // Data bit 5 of 0x5A is 0, so the line is low just before reset.
        total++;
        if (txl[0] !== 1'b0) begin
            bad++;
            $display("FAIL midreset_pre: got tx=%b want 0", txl[0]);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (txl[0] !== 1'b1 || bsy[0] !== 1'b0 || fd[0] !== 1'b0) begin
            bad++;
            $display("FAIL midreset_async: got tx=%b busy=%b done=%b want 1 0 0",
                     txl[0], bsy[0], fd[0]);
        end
        push(0, 8'h96);
        @(negedge clk);
        rst_n = 1'b1;
        check_frame(0, 8'h96, -1, g);
    endtask

    task automatic test_underrun();
        int g;
        int r0;
        bit saw_low;
        bit saw_done;
        r0 = rdy_cnt[0];
        suppress[0] = 1'b1;
        push(0, 8'h11);
        saw_low = 1'b0;
        saw_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (txl[0] == 1'b0) saw_low = 1'b1;
            if (fd[0] == 1'b1) saw_done = 1'b1;
        end
        total++;
        if (ur[0] !== 1'b1) begin
            bad++;
            $display("FAIL underrun_flag: got %b want 1", ur[0]);
        end
        total++;
        if (saw_low || saw_done || bsy[0] !== 1'b0 || rdy_cnt[0] - r0 != 1) begin
            bad++;
            $display("FAIL underrun_quiet: got low=%b done=%b busy=%b pulses=%0d want 0 0 0 1",
                     saw_low, saw_done, bsy[0], rdy_cnt[0] - r0);
        end
        suppress[0] = 1'b0;
        push(0, 8'h22);
        check_frame(0, 8'h22, -1, g);
        total++;
        if (ur[0] !== 1'b1) begin
            bad++;
            $display("FAIL underrun_sticky: got %b want 1", ur[0]);
        end
    endtask

    task automatic test_random();
        int g;
        int i;
        logic [7:0] d;
        ten = 3'b111;
        for (int n = 0; n < 9; n++) begin
            i = int'($urandom_range(0, 2));
            d = 8'($urandom);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            push(i, d);
            check_frame(i, d, -1, g);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_parity();
        test_tx_en_drop();
        test_reset_mid();
        test_underrun();
        test_random();
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
